vq_encoder: RTL and testbench

- Vector-quantisation compression stage. It sits directly upstream of the decompressor and produces the tag RAM contents that the decompressor consumes.
- For each pixel of a 64x64 RGB picture held in the picture RAM, it finds the nearest of 64 codebook entries (codebook RAM) by squared Euclidean distance. It then writes that entry's index to the tag RAM.
- Uses the same three-RAM interface style and `done` flag as the decompressor, so the two stages share one RAM model and one bench infrastructure.

---
 rtl/vq_encoder.sv | 190 +++++++++++++++++++
 tb/tb_vq_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vq_encoder.sv
// Vector-quantisation encoder: loads a 64-entry RGB codebook, then for every pixel
// writes the index of the nearest codeword (squared Euclidean distance) to the tag RAM.
module vq_encoder #(
   parameter int PIXELS    = 4096,
   parameter int CODEWORDS = 64,
   parameter int IDX_W     = 6,
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] RAM_W_Q,
   output logic [DATA_W-1:0] RAM_W_D,
   output logic [ADDR_W-1:0] RAM_W_A,
   output logic              RAM_W_WE,
   output logic              RAM_W_OE,
   input  logic [DATA_W-1:0] RAM_PIC_Q,
   output logic [DATA_W-1:0] RAM_PIC_D,
   output logic [ADDR_W-1:0] RAM_PIC_A,
   output logic              RAM_PIC_WE,
   output logic              RAM_PIC_OE,
   input  logic [DATA_W-1:0] RAM_TAG_Q,
   output logic [DATA_W-1:0] RAM_TAG_D,
   output logic [ADDR_W-1:0] RAM_TAG_A,
   output logic              RAM_TAG_WE,
   output logic              RAM_TAG_OE,
   output logic              done
);

   localparam int CNT_W  = IDX_W + 1;
   localparam int DIST_W = 18;

   typedef enum logic [2:0] {LOAD, FETCH, LATCH, SEARCH, WRITE, DONE} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_pixCnt;
   logic [DATA_W-1:0]   r_cb [CODEWORDS];
   logic [DATA_W-1:0]   r_pix;
   logic [15:0]         r_sq0;
   logic [15:0]         r_sq1;
   logic [15:0]         r_sq2;
   logic                r_s1Valid;
   logic [IDX_W-1:0]    r_s1Idx;
   logic [DIST_W-1:0]   r_bestDist;
   logic [IDX_W-1:0]    r_bestIdx;

   logic [ADDR_W-1:0]   r_wA;
   logic                r_wOe;
   logic [ADDR_W-1:0]   r_picA;
   logic                r_picOe;
   logic [ADDR_W-1:0]   r_tagA;
   logic [DATA_W-1:0]   r_tagD;
   logic                r_tagWe;
   logic                r_done;

   logic [IDX_W-1:0]    w_capIdx;
   logic [DATA_W-1:0]   w_cbWord;
   logic [DIST_W-1:0]   w_dist;
   logic                w_better;
   logic [DIST_W-1:0]   w_nextDist;
   logic [IDX_W-1:0]    w_nextIdx;
   logic                w_unused;

   // Square of the magnitude of the 9-bit signed channel difference; fits 16 bits unsigned.
   function automatic logic [15:0] sqDiff(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] mag;
      mag = (a >= b) ? (a - b) : (b - a);
      return 16'(mag) * 16'(mag);
   endfunction

   // Codebook read data lags its address by two counts of r_cnt (issue, then RAM latency).
   assign w_capIdx   = r_cnt[IDX_W-1:0] - IDX_W'(2);
   assign w_cbWord   = r_cb[r_cnt[IDX_W-1:0]];
   assign w_dist     = DIST_W'(r_sq0) + DIST_W'(r_sq1) + DIST_W'(r_sq2);
   assign w_better   = r_s1Valid && (w_dist < r_bestDist);
   assign w_nextDist = w_better ? w_dist : r_bestDist;
   assign w_nextIdx  = w_better ? r_s1Idx : r_bestIdx;
   assign w_unused   = ^RAM_TAG_Q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= LOAD;
         r_cnt      <= '0;
         r_pixCnt   <= '0;
         r_pix      <= '0;
         r_sq0      <= '0;
         r_sq1      <= '0;
         r_sq2      <= '0;
         r_s1Valid  <= 1'b0;
         r_s1Idx    <= '0;
         r_bestDist <= '0;
         r_bestIdx  <= '0;
         r_wA       <= '0;
         r_wOe      <= 1'b0;
         r_picA     <= '0;
         r_picOe    <= 1'b0;
         r_tagA     <= '0;
         r_tagD     <= '0;
         r_tagWe    <= 1'b0;
         r_done     <= 1'b0;
         for (int i = 0; i < CODEWORDS; i++) r_cb[i] <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               if (r_cnt >= CNT_W'(2)) r_cb[w_capIdx] <= RAM_W_Q;
               if (r_cnt < CNT_W'(CODEWORDS)) begin
                  r_wA  <= ADDR_W'(r_cnt);
                  r_wOe <= 1'b1;
               end else begin
                  r_wA  <= '0;
                  r_wOe <= 1'b0;
               end
               if (r_cnt == CNT_W'(CODEWORDS + 1)) begin
                  r_picA  <= r_pixCnt;
                  r_picOe <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= FETCH;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            FETCH: begin
               r_picOe <= 1'b0;
               r_state <= LATCH;
            end
            LATCH: begin
               r_pix      <= RAM_PIC_Q;
               r_bestDist <= '1;
               r_bestIdx  <= '0;
               r_s1Valid  <= 1'b0;
               r_cnt      <= '0;
               r_state    <= SEARCH;
            end
            SEARCH: begin
               if (r_cnt < CNT_W'(CODEWORDS)) begin
                  r_sq0     <= sqDiff(r_pix[7:0],   w_cbWord[7:0]);
                  r_sq1     <= sqDiff(r_pix[15:8],  w_cbWord[15:8]);
                  r_sq2     <= sqDiff(r_pix[23:16], w_cbWord[23:16]);
                  r_s1Idx   <= r_cnt[IDX_W-1:0];
                  r_s1Valid <= 1'b1;
               end else begin
                  r_s1Valid <= 1'b0;
               end
               r_bestDist <= w_nextDist;
               r_bestIdx  <= w_nextIdx;
               // The last compare resolves on this edge, so the tag comes straight from it.
               if (r_cnt == CNT_W'(CODEWORDS)) begin
                  r_tagA  <= r_pixCnt;
                  r_tagD  <= DATA_W'(w_nextIdx);
                  r_tagWe <= 1'b1;
                  r_state <= WRITE;
               end
               r_cnt <= r_cnt + CNT_W'(1);
            end
            WRITE: begin
               r_tagWe <= 1'b0;
               if (r_pixCnt == ADDR_W'(PIXELS - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_pixCnt <= r_pixCnt + ADDR_W'(1);
                  r_picA   <= r_pixCnt + ADDR_W'(1);
                  r_picOe  <= 1'b1;
                  r_state  <= FETCH;
               end
            end
            DONE: begin
               r_done <= 1'b1;
            end
            default: r_state <= LOAD;
         endcase
      end
   end

   assign RAM_W_D    = '0;
   assign RAM_W_A    = r_wA;
   assign RAM_W_WE   = 1'b0;
   assign RAM_W_OE   = r_wOe;
   assign RAM_PIC_D  = '0;
   assign RAM_PIC_A  = r_picA;
   assign RAM_PIC_WE = 1'b0;
   assign RAM_PIC_OE = r_picOe;
   assign RAM_TAG_D  = r_tagD;
   assign RAM_TAG_A  = r_tagA;
   assign RAM_TAG_WE = r_tagWe;
   assign RAM_TAG_OE = 1'b0;
   assign done       = r_done;

endmodule

// File: tb/tb_vq_encoder.sv
// Directed bench for vq_encoder on a reduced 8-pixel picture with behavioural
// codebook, picture and tag RAMs plus a per-cycle protocol monitor.
module tb_vq_encoder;

   localparam int NPIX     = 8;
   localparam int DONE_CYC = 65 + 68 * NPIX + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] wQ = '0;
   logic [23:0] wD;
   logic [19:0] wA;
   logic        wWe;
   logic        wOe;
   logic [23:0] picQ = '0;
   logic [23:0] picD;
   logic [19:0] picA;
   logic        picWe;
   logic        picOe;
   logic [23:0] tagQ = '0;
   logic [23:0] tagD;
   logic [19:0] tagA;
   logic        tagWe;
   logic        tagOe;
   logic        done;

   logic [23:0] cbMem [64];
   logic [23:0] picMem [NPIX];
   logic [23:0] tagMem [NPIX];
   int          wrCnt [NPIX];
   int          firstAddr = -1;
   int          total = 0;
   int          bad = 0;
   logic        prevDone = 1'b0;

   vq_encoder #(.PIXELS(NPIX)) dut (
      .clk(clk), .rst(rst),
      .RAM_W_Q(wQ), .RAM_W_D(wD), .RAM_W_A(wA), .RAM_W_WE(wWe), .RAM_W_OE(wOe),
      .RAM_PIC_Q(picQ), .RAM_PIC_D(picD), .RAM_PIC_A(picA), .RAM_PIC_WE(picWe), .RAM_PIC_OE(picOe),
      .RAM_TAG_Q(tagQ), .RAM_TAG_D(tagD), .RAM_TAG_A(tagA), .RAM_TAG_WE(tagWe), .RAM_TAG_OE(tagOe),
      .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous RAMs: read data one cycle after address+OE, writes on the WE edge.
   always @(posedge clk) begin
      if (wOe) wQ <= cbMem[wA[5:0]];
      if (picOe) picQ <= picMem[picA[2:0]];
      if (tagWe) begin
         tagMem[tagA[2:0]] = tagD;
         wrCnt[tagA[2:0]] = wrCnt[tagA[2:0]] + 1;
         if (firstAddr < 0) firstAddr = int'(tagA);
      end
   end

   // Protocol monitor: tied signals, enable exclusivity, tag address range, sticky done.
   always @(negedge clk) begin
      if (rst) begin
         total++;
         if (wWe !== 1'b0 || picWe !== 1'b0 || tagOe !== 1'b0 || wD !== 24'h0 || picD !== 24'h0
             || !$onehot0({wOe, picOe, tagWe}) || (done && (wOe || picOe || tagWe))) begin
            bad++;
            $display("[TB] FAIL protocol: wWe=%b picWe=%b tagOe=%b wOe=%b picOe=%b tagWe=%b done=%b, required tied low and at most one enable",
                     wWe, picWe, tagOe, wOe, picOe, tagWe, done);
         end
         if (tagWe && tagA >= 20'(NPIX)) begin
            bad++;
            $display("[TB] FAIL tag_range: addr=%0d, required < %0d", tagA, NPIX);
         end
         if (prevDone && !done) begin
            bad++;
            $display("[TB] FAIL done_sticky: done=%b, required 1", done);
         end
         prevDone = done;
      end else begin
         prevDone = 1'b0;
      end
   end

   // Holds reset a few cycles, clears the tag scoreboard, releases on a falling edge.
   task automatic applyStimulus();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NPIX; i++) begin
         wrCnt[i]  = 0;
         tagMem[i] = 24'hEEEEEE;
      end
      firstAddr = -1;
      rst = 1'b1;
   endtask

   task automatic waitDone(output int cyc);
      cyc = 0;
      while (cyc < DONE_CYC + 100 && done !== 1'b1) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (done !== 1'b0 || wOe !== 1'b0 || picOe !== 1'b0 || tagWe !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: done=%b wOe=%b picOe=%b tagWe=%b, required all 0", done, wOe, picOe, tagWe);
      end
      total++;
      if (wA !== 20'h0 || picA !== 20'h0 || tagA !== 20'h0 || tagD !== 24'h0) begin
         bad++;
         $display("[TB] FAIL reset_bus: wA=%h picA=%h tagA=%h tagD=%h, required all 0", wA, picA, tagA, tagD);
      end
      for (int k = 0; k < 64; k++) cbMem[k] = {8'(k * 4), 8'(k * 4), 8'(k * 4)};
      for (int p = 0; p < NPIX; p++) picMem[p] = 24'h282828;
      rst = 1'b1;
      for (int c = 1; c <= 66; c++) begin
         @(posedge clk);
         #1;
         if (c == 1 || c == 2 || c == 64) begin
            total++;
            if (wOe !== 1'b1 || wA !== 20'(c - 1)) begin
               bad++;
               $display("[TB] FAIL load_addr cycle %0d: wOe=%b wA=%0d, required 1 and %0d", c, wOe, wA, c - 1);
            end
         end
         if (c == 65) begin
            total++;
            if (wOe !== 1'b0) begin
               bad++;
               $display("[TB] FAIL load_end: wOe=%b, required 0", wOe);
            end
         end
         if (c == 66) begin
            total++;
            if (picOe !== 1'b1 || picA !== 20'h0) begin
               bad++;
               $display("[TB] FAIL first_fetch: picOe=%b picA=%0d, required 1 and 0", picOe, picA);
            end
         end
      end
   endtask

   task automatic test_ramp();
      int cyc;
      for (int k = 0; k < 64; k++) cbMem[k] = {8'(k * 4), 8'(k * 4), 8'(k * 4)};
      for (int p = 0; p < NPIX; p++) picMem[p] = 24'h282828;
      applyStimulus();
      waitDone(cyc);
      total++;
      if (cyc != DONE_CYC) begin
         bad++;
         $display("[TB] FAIL ramp_done_cycle: got %0d, required %0d", cyc, DONE_CYC);
      end
      for (int p = 0; p < NPIX; p++) begin
         total++;
         if (tagMem[p] !== 24'h00000A || wrCnt[p] != 1) begin
            bad++;
            $display("[TB] FAIL ramp_tag[%0d]: got %h (writes %0d), required 00000a (writes 1)", p, tagMem[p], wrCnt[p]);
         end
      end
      total++;
      if (firstAddr != 0) begin
         bad++;
         $display("[TB] FAIL ramp_first_addr: got %0d, required 0", firstAddr);
      end
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL done_hold: got %b, required 1", done);
      end
   endtask

   task automatic test_tie();
      int cyc;
      for (int k = 0; k < 64; k++) cbMem[k] = 24'hFFFFFF;
      cbMem[3] = 24'h102030;
      cbMem[9] = 24'h102030;
      for (int p = 0; p < NPIX; p++) picMem[p] = 24'h102030;
      applyStimulus();
      waitDone(cyc);
      for (int p = 0; p < NPIX; p++) begin
         total++;
         if (tagMem[p] !== 24'h000003) begin
            bad++;
            $display("[TB] FAIL tie_tag[%0d]: got %h, required 000003", p, tagMem[p]);
         end
      end
   endtask

   task automatic test_extremes();
      int cyc;
      for (int k = 0; k < 64; k++) cbMem[k] = 24'h808080;
      cbMem[0]  = 24'h000000;
      cbMem[63] = 24'hFFFFFF;
      for (int p = 0; p < NPIX; p++) picMem[p] = p[0] ? 24'hFFFFFF : 24'h000000;
      applyStimulus();
      waitDone(cyc);
      for (int p = 0; p < NPIX; p++) begin
         total++;
         if (tagMem[p] !== (p[0] ? 24'h00003F : 24'h000000)) begin
            bad++;
            $display("[TB] FAIL extreme_tag[%0d]: got %h, required %h", p, tagMem[p], p[0] ? 24'h00003F : 24'h000000);
         end
      end
   endtask

   // Entry 0 sits at distance 195075 and the rest at 71148; a truncated sum would pick entry 0.
   task automatic test_overflow();
      int cyc;
      for (int k = 0; k < 64; k++) cbMem[k] = 24'h9A9A9A;
      cbMem[0] = 24'hFFFFFF;
      for (int p = 0; p < NPIX; p++) picMem[p] = p[0] ? 24'hFFFFFF : 24'h000000;
      applyStimulus();
      waitDone(cyc);
      for (int p = 0; p < NPIX; p++) begin
         total++;
         if (tagMem[p] !== (p[0] ? 24'h000000 : 24'h000001)) begin
            bad++;
            $display("[TB] FAIL overflow_tag[%0d]: got %h, required %h", p, tagMem[p], p[0] ? 24'h000000 : 24'h000001);
         end
      end
   endtask

   task automatic test_channels();
      int          cyc;
      logic [23:0] pat [4];
      logic [23:0] exp [4];
      pat = '{24'hF00000, 24'h00F000, 24'h0000F0, 24'h101010};
      exp = '{24'h000005, 24'h000006, 24'h000007, 24'h000000};
      for (int k = 0; k < 64; k++) cbMem[k] = 24'h000000;
      cbMem[5] = 24'hFF0000;
      cbMem[6] = 24'h00FF00;
      cbMem[7] = 24'h0000FF;
      for (int p = 0; p < NPIX; p++) picMem[p] = pat[p % 4];
      applyStimulus();
      waitDone(cyc);
      for (int p = 0; p < NPIX; p++) begin
         total++;
         if (tagMem[p] !== exp[p % 4]) begin
            bad++;
            $display("[TB] FAIL channel_tag[%0d]: got %h, required %h", p, tagMem[p], exp[p % 4]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      int cyc;
      for (int k = 0; k < 64; k++) cbMem[k] = {8'(k * 4), 8'(k * 4), 8'(k * 4)};
      for (int p = 0; p < NPIX; p++) picMem[p] = 24'h282828;
      applyStimulus();
      // Cycle 289 lies inside the search of pixel 3.
      repeat (289) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (done !== 1'b0 || wOe !== 1'b0 || picOe !== 1'b0 || tagWe !== 1'b0
          || wA !== 20'h0 || picA !== 20'h0 || tagA !== 20'h0 || tagD !== 24'h0) begin
         bad++;
         $display("[TB] FAIL abort_outputs: done=%b wOe=%b picOe=%b tagWe=%b wA=%h picA=%h tagA=%h tagD=%h, required all 0",
                  done, wOe, picOe, tagWe, wA, picA, tagA, tagD);
      end
      total++;
      if (wrCnt[0] != 1 || wrCnt[1] != 1 || wrCnt[2] != 1 || wrCnt[3] != 0) begin
         bad++;
         $display("[TB] FAIL abort_partial: writes %0d %0d %0d %0d, required 1 1 1 0", wrCnt[0], wrCnt[1], wrCnt[2], wrCnt[3]);
      end
      for (int p = 0; p < NPIX; p++) picMem[p] = 24'h505050;
      applyStimulus();
      waitDone(cyc);
      total++;
      if (cyc != DONE_CYC || firstAddr != 0) begin
         bad++;
         $display("[TB] FAIL restart: done cycle %0d first addr %0d, required %0d and 0", cyc, firstAddr, DONE_CYC);
      end
      for (int p = 0; p < NPIX; p++) begin
         total++;
         if (tagMem[p] !== 24'h000014 || wrCnt[p] != 1) begin
            bad++;
            $display("[TB] FAIL restart_tag[%0d]: got %h (writes %0d), required 000014 (writes 1)", p, tagMem[p], wrCnt[p]);
         end
      end
   endtask

   initial begin
      $display("[TB] vq_encoder directed tests, %0d pixels", NPIX);
      test_reset();
      test_ramp();
      test_tie();
      test_extremes();
      test_overflow();
      test_channels();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
